// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Fills the instruction memory from a host byte stream before the RISC
//   core is allowed to run. A frame is LEN_HI, LEN_LO (word count N,
//   big-endian), then 3*N payload bytes. Each word is sent MSB first.
//   Every assembled 24-bit word is written to consecutive IM addresses
//   starting at 0. The core is held in reset until a frame loads cleanly.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, one extra byte follows the payload. It is the XOR of all
//     3*N payload bytes (0x00 for N=0). A mismatch rejects the frame. Words
//     already written stay in IM, but the core stays in reset.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low
//   start       in   1-cycle pulse: begin (or restart) a load frame
//   byte_in     in   [7:0] stream byte
//   byte_valid  in   byte_in valid
//   byte_ready  out  loader accepts byte_in this cycle
//   im_we       out  IM write strobe, one cycle per word
//   im_addr     out  [ADDR_W-1:0] IM write address (held between writes)
//   im_wdata    out  [INSTR_W-1:0] IM write data (held between writes)
//   cpu_reset   out  active-high core reset; low only after a good load
//   load_done   out  level: frame loaded successfully
//   load_err    out  level: frame rejected
//   load_count  out  [ADDR_W-1:0] words written in the current frame
//   state_dbg   out  [2:0] current FSM state encoding
//
// Handshake: a byte moves only on a rising edge where byte_valid && byte_ready.
//   byte_ready depends only on the FSM state, never on byte_valid.
//   The producer holds byte_in stable while byte_valid is high and ready is low.
//   byte_valid in a non-accepting state is ignored and consumes nothing.
module instr_mem_loader #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 24,
  parameter int DEPTH   = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_err,
  output logic [ADDR_W-1:0]  load_count,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        len_q;
  logic [1:0]         byte_idx_q;
  logic [INSTR_W-1:0] word_q;
  logic               xfer;
  logic [15:0]        len_new;
  logic [ADDR_W-1:0]  count_inc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA)   || (state_q == CHK);
  assign xfer       = byte_valid && byte_ready;
  assign len_new    = {len_q[15:8], byte_in};
  assign count_inc  = load_count + 1'b1;

  // Status outputs are pure decodes of the state, so they cannot disagree with it.
  assign im_we     = (state_q == WRITE);
  assign cpu_reset = (state_q != DONE);
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERR);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = LEN_HI;
      LEN_HI: if (xfer) state_d = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (32'(len_new) > 32'(DEPTH)) state_d = ERR;
`ifdef LOADER_CHECKSUM_EN
          else if (len_new == 16'd0)     state_d = CHK;
`else
          else if (len_new == 16'd0)     state_d = DONE;
`endif
          else                           state_d = DATA;
        end
      end
      DATA:   if (xfer && (byte_idx_q == 2'd2)) state_d = WRITE;
      WRITE: begin
        // The DEPTH check on N keeps count_inc from wrapping.
        if (16'(count_inc) == len_q)
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        else
          state_d = DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK:    if (xfer) state_d = (byte_in == csum_q) ? DONE : ERR;
`endif
      DONE:   if (start) state_d = LEN_HI;
      ERR:    if (start) state_d = LEN_HI;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      im_addr    <= '0;
      im_wdata   <= '0;
      load_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE, ERR: begin
          // A new frame starts from word 0 with a fresh checksum.
          if (start) begin
            load_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        LEN_HI: if (xfer) len_q[15:8] <= byte_in;
        LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= byte_in;
            byte_idx_q <= 2'd0;
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ byte_in;
`endif
            case (byte_idx_q)
              2'd0: begin
                word_q[23:16] <= byte_in;
                byte_idx_q    <= 2'd1;
              end
              2'd1: begin
                word_q[15:8] <= byte_in;
                byte_idx_q   <= 2'd2;
              end
              default: begin
                // The write port is loaded here so im_addr/im_wdata stay
                // fixed after the strobe while load_count moves on.
                im_addr    <= load_count;
                im_wdata   <= {word_q[INSTR_W-1:8], byte_in};
                byte_idx_q <= 2'd0;
              end
            endcase
          end
        end
        WRITE: load_count <= count_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 24;
  localparam int DEPTH   = 256;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic [7:0]         byte_in = 8'h00;
  logic               byte_valid = 1'b0;
  logic               byte_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;
  logic               cpu_reset;
  logic               load_done;
  logic               load_err;
  logic [ADDR_W-1:0]  load_count;
  logic [2:0]         state_dbg;

  instr_mem_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_err(load_err), .load_count(load_count),
    .state_dbg(state_dbg)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [39:0] exp_q[$];   // {addr[15:0], data[23:0]}
  logic [7:0]  tx_q[$];
  logic [23:0] words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // scoreboard monitor: every IM write must match the next expected word
  always @(negedge clk) begin
    if (reset && im_we) begin
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", im_addr, im_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("im_addr", 32'(im_addr), 32'(e[39:24]));
        check("im_wdata", 32'(im_wdata), 32'(e[23:0]));
      end
    end
  end

  // driver tasks (all called at a falling edge)
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [7:0] bsel(input logic [23:0] w, input int k);
    if (k == 0) return w[23:16];
    if (k == 1) return w[15:8];
    return w[7:0];
  endfunction

  task automatic build_frame(input logic [15:0] n, input bit push_exp, input bit bad_csum);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    tx_q.delete();
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    for (int i = 0; i < words.size(); i++) begin
      for (int k = 0; k < 3; k++) begin
        b = bsel(words[i], k);
        tx_q.push_back(b);
        cs = cs ^ b;
      end
      if (push_exp) exp_q.push_back({16'(i), words[i]});
    end
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(bad_csum ? 8'h00 : cs);
`else
    if (bad_csum) cs = 8'h00;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        timeout_fail("byte_ready");
        byte_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);   // transfer happens on the rising edge just passed
    byte_valid = 1'b0;
  endtask

  task automatic send_tx(input int first, input int last, input int gap_max, input bit mid_start);
    for (int i = first; i <= last; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      if (mid_start && (i == 3 || i == 6)) pulse_start();
      send_byte(tx_q[i]);
    end
  endtask

  task automatic wait_end(input string name);
    int g;
    g = 0;
    while (!(load_done || load_err)) begin
      @(negedge clk);
      g++;
      if (g > 100) begin
        timeout_fail(name);
        return;
      end
    end
  endtask

  task automatic check_done(input string name, input int cnt);
    check({name, "_done"}, 32'(load_done), 32'd1);
    check({name, "_err"}, 32'(load_err), 32'd0);
    check({name, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({name, "_count"}, 32'(load_count), 32'(cnt));
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test2_words();
    words.delete();
    words.push_back(24'h123456);
    words.push_back(24'hABCDEF);
  endtask

  initial begin
    // 1: reset values
    repeat (2) @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", 32'(im_wdata), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    byte_in = 8'h55;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_byte_ready", 32'(byte_ready), 32'd0);
    check("idle_state", 32'(state_dbg), 32'd0);
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    byte_valid = 1'b0;

    // 2: two-word frame
    test2_words();
    build_frame(16'd2, 1'b1, 1'b0);
    pulse_start();
    send_tx(0, tx_q.size() - 1, 0, 1'b0);
    wait_end("t2");
    check_done("t2", 2);

    // 3: length above DEPTH
    words.delete();
    build_frame(16'h0101, 1'b0, 1'b0);
    pulse_start();
    send_tx(0, 1, 0, 1'b0);
    wait_end("t3");
    check("t3_err", 32'(load_err), 32'd1);
    check("t3_done", 32'(load_done), 32'd0);
    check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t3_count", 32'(load_count), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_err_holds", 32'(load_err), 32'd1);

    // 4: random valid gaps plus stray start pulses mid-frame
    test2_words();
    build_frame(16'd2, 1'b1, 1'b0);
    pulse_start();
    send_tx(0, tx_q.size() - 1, 3, 1'b1);
    wait_end("t4");
    check_done("t4", 2);

    // 5: async reset after 4 payload bytes, then a clean reload
    test2_words();
    build_frame(16'd2, 1'b0, 1'b0);
    exp_q.push_back({16'd0, 24'h123456});
    pulse_start();
    send_tx(0, 5, 0, 1'b0);
    reset = 1'b0;
    #1;
    check("t5_im_we", 32'(im_we), 32'd0);
    check("t5_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t5_byte_ready", 32'(byte_ready), 32'd0);
    check("t5_count", 32'(load_count), 32'd0);
    check("t5_state", 32'(state_dbg), 32'd0);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    build_frame(16'd2, 1'b1, 1'b0);
    pulse_start();
    send_tx(0, tx_q.size() - 1, 0, 1'b0);
    wait_end("t5b");
    check_done("t5b", 2);

    // N == 0 boundary
    words.delete();
    build_frame(16'd0, 1'b0, 1'b0);
    pulse_start();
    send_tx(0, tx_q.size() - 1, 0, 1'b0);
    wait_end("n0");
    check_done("n0", 0);

    // N == DEPTH boundary: full memory
    words.delete();
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      words.push_back({iv, ~iv, iv ^ 8'h5A});
    end
    build_frame(16'(DEPTH), 1'b1, 1'b0);
    pulse_start();
    send_tx(0, tx_q.size() - 1, 0, 1'b0);
    wait_end("full");
    check_done("full", DEPTH);

`ifdef LOADER_CHECKSUM_EN
    // 6: bad checksum rejects, words still written; then a correct reload
    test2_words();
    build_frame(16'd2, 1'b1, 1'b1);
    pulse_start();
    send_tx(0, tx_q.size() - 1, 0, 1'b0);
    wait_end("t6");
    check("t6_err", 32'(load_err), 32'd1);
    check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t6_count", 32'(load_count), 32'd2);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    build_frame(16'd2, 1'b1, 1'b0);
    pulse_start();
    send_tx(0, tx_q.size() - 1, 0, 1'b0);
    wait_end("t6b");
    check_done("t6b", 2);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
